motor_copia_mem512: RTL and testbench

Memory-side initiator for the 512x16 word memory. It drives the memory's data-in, address and write-enable ports and reads its data-out port. Three bulk operations run autonomously: fill a range with a pattern, copy a range, and compute a 16-bit additive checksum over a range. It sits between the control logic and the memory, and the memory is its only responder.

---
 rtl/motor_copia_mem512.sv | 196 +++++++++++++++++++
 tb/tb_motor_copia_mem512.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_copia_mem512.sv
// motor_copia_mem512: memory-side initiator for a 512x16 word memory.
// Runs three autonomous bulk operations over an address range: fill with a
// pattern, ascending copy, and a 16-bit additive checksum. Addresses wrap
// modulo the memory size.
module motor_copia_mem512 #(
  parameter int LARGURA = 16,
  parameter int ADDR    = 9
) (
  input  logic               sinal_clock,
  input  logic               sinal_reset,
  input  logic               start,
  input  logic [1:0]         modo,
  input  logic [ADDR-1:0]    origem,
  input  logic [ADDR-1:0]    destino,
  input  logic [ADDR:0]      quantidade,
  input  logic [LARGURA-1:0] padrao,
  output logic               busy,
  output logic               done,
  output logic               erro,
  output logic [LARGURA-1:0] soma,
  output logic [LARGURA-1:0] mem_entrada,
  output logic [ADDR-1:0]    mem_posicao,
  output logic               mem_write,
  input  logic [LARGURA-1:0] mem_saida
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    COPY_RD = 3'd2,
    COPY_WR = 3'd3,
    SUM     = 3'd4,
    FIM     = 3'd5
  } estado_t;

  typedef enum logic [1:0] {
    M_FILL   = 2'b00,
    M_COPY   = 2'b01,
    M_SUM    = 2'b10,
    M_ILEGAL = 2'b11
  } modo_t;

  // Largest legal word count: the full memory.
  localparam logic [ADDR:0]   MAX_QTD = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0]   UM_CNT  = {{ADDR{1'b0}}, 1'b1};
  localparam logic [ADDR-1:0] UM_IDX  = {{(ADDR-1){1'b0}}, 1'b1};

  estado_t            estado_q,  estado_d;
  logic [ADDR-1:0]    origem_q,  origem_d;
  logic [ADDR-1:0]    destino_q, destino_d;
  logic [LARGURA-1:0] padrao_q,  padrao_d;
  logic [ADDR:0]      cnt_q,     cnt_d;     // words still to process
  logic [ADDR-1:0]    idx_q,     idx_d;     // offset i from the base address
  logic [LARGURA-1:0] dado_q,    dado_d;    // word held between COPY_RD and COPY_WR
  logic [LARGURA-1:0] soma_q,    soma_d;
  logic               erro_q,    erro_d;

  logic ultimo;
  assign ultimo = (cnt_q == UM_CNT);

  // State register: all sequential state, synchronous active-high reset.
  always_ff @(posedge sinal_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (sinal_reset) begin
      estado_q  <= IDLE;
      origem_q  <= '0;
      destino_q <= '0;
      padrao_q  <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      dado_q    <= '0;
      soma_q    <= '0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      origem_q  <= origem_d;
      destino_q <= destino_d;
      padrao_q  <= padrao_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dado_q    <= dado_d;
      soma_q    <= soma_d;
      erro_q    <= erro_d;
    end
  end

  // Next-state logic: operation sequencing, counters, checksum, hold register.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    estado_d  = estado_q;
    origem_d  = origem_q;
    destino_d = destino_q;
    padrao_d  = padrao_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dado_d    = dado_q;
    soma_d    = soma_q;
    erro_d    = erro_q;

    unique case (estado_q)
      IDLE: begin
        if (start) begin
          origem_d  = origem;
          destino_d = destino;
          padrao_d  = padrao;
          cnt_d     = quantidade;
          idx_d     = '0;
          soma_d    = '0;
          erro_d    = 1'b0;
          if ((quantidade > MAX_QTD) || (modo_t'(modo) == M_ILEGAL)) begin
            erro_d   = 1'b1;
            estado_d = FIM;
          end else if (quantidade == '0) begin
            estado_d = FIM;
          end else begin
            unique case (modo_t'(modo))
              M_FILL:  estado_d = FILL;
              M_COPY:  estado_d = COPY_RD;
              default: estado_d = SUM;
            endcase
          end
        end
      end
      FILL: begin
        idx_d = idx_q + UM_IDX;
        cnt_d = cnt_q - UM_CNT;
        if (ultimo) estado_d = FIM;
      end
      COPY_RD: begin
        dado_d   = mem_saida;
        estado_d = COPY_WR;
      end
      COPY_WR: begin
        idx_d    = idx_q + UM_IDX;
        cnt_d    = cnt_q - UM_CNT;
        estado_d = ultimo ? FIM : COPY_RD;
      end
      SUM: begin
        soma_d = soma_q + mem_saida;  // carry out of bit 15 is dropped
        idx_d  = idx_q + UM_IDX;
        cnt_d  = cnt_q - UM_CNT;
        if (ultimo) estado_d = FIM;
      end
      FIM: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  // Output logic: memory port and status flags decoded from the current state.
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    mem_write   = 1'b0;
    mem_posicao = '0;
    mem_entrada = '0;

    unique case (estado_q)
      FILL: begin
        busy        = 1'b1;
        mem_posicao = destino_q + idx_q;
        mem_entrada = padrao_q;
        mem_write   = 1'b1;
      end
      COPY_RD: begin
        busy        = 1'b1;
        mem_posicao = origem_q + idx_q;
      end
      COPY_WR: begin
        busy        = 1'b1;
        mem_posicao = destino_q + idx_q;
        mem_entrada = dado_q;
        mem_write   = 1'b1;
      end
      SUM: begin
        busy        = 1'b1;
        mem_posicao = origem_q + idx_q;
      end
      FIM: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign erro = erro_q;
  assign soma = soma_q;

endmodule

// File: tb/tb_motor_copia_mem512.sv
// Testbench for motor_copia_mem512: a behavioural 512x16 memory as the
// responder, a table of directed operations with hand-computed results, and
// hand-written sequences for reset mid-fill and start while busy.
module tb_motor_copia_mem512;

  logic        sinal_clock = 1'b0;
  logic        sinal_reset;
  logic        start;
  logic [1:0]  modo;
  logic [8:0]  origem;
  logic [8:0]  destino;
  logic [9:0]  quantidade;
  logic [15:0] padrao;
  logic        busy;
  logic        done;
  logic        erro;
  logic [15:0] soma;
  logic [15:0] mem_entrada;
  logic [8:0]  mem_posicao;
  logic        mem_write;
  logic [15:0] mem_saida;

  always #5 sinal_clock = ~sinal_clock;

  motor_copia_mem512 #(.LARGURA(16), .ADDR(9)) dut (
    .sinal_clock (sinal_clock),
    .sinal_reset (sinal_reset),
    .start       (start),
    .modo        (modo),
    .origem      (origem),
    .destino     (destino),
    .quantidade  (quantidade),
    .padrao      (padrao),
    .busy        (busy),
    .done        (done),
    .erro        (erro),
    .soma        (soma),
    .mem_entrada (mem_entrada),
    .mem_posicao (mem_posicao),
    .mem_write   (mem_write),
    .mem_saida   (mem_saida)
  );

  // Behavioural memory: asynchronous read, write committed at the rising edge
  // that ends the cycle in which mem_write was high.
  logic [15:0] mem [512];
  logic        pend_we;
  logic [8:0]  pend_addr;
  logic [15:0] pend_data;
  logic        tb_we;
  logic        tb_clr;
  logic [8:0]  tb_addr;
  logic [15:0] tb_data;

  assign mem_saida = mem[mem_posicao];

  always @(negedge sinal_clock) begin
    pend_we   <= mem_write;
    pend_addr <= mem_posicao;
    pend_data <= mem_entrada;
  end

  always @(posedge sinal_clock) begin
    if (tb_clr) begin
      for (int k = 0; k < 512; k++) mem[k] <= 16'h0000;
    end else begin
      if (pend_we) mem[pend_addr] <= pend_data;
      if (tb_we)   mem[tb_addr]   <= tb_data;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  task automatic mem_clear();
    @(negedge sinal_clock);
    tb_clr = 1'b1;
    @(negedge sinal_clock);
    tb_clr = 1'b0;
  endtask

  task automatic mem_load(input logic [8:0] a, input logic [15:0] d);
    @(negedge sinal_clock);
    tb_we   = 1'b1;
    tb_addr = a;
    tb_data = d;
    @(negedge sinal_clock);
    tb_we = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  modo;
    logic [8:0]  origem;
    logic [8:0]  destino;
    logic [9:0]  quantidade;
    logic [15:0] padrao;
    logic        exp_erro;
    logic [15:0] exp_soma;
    int          exp_lat;     // start edge to done, in cycles
    int          exp_wr;      // number of mem_write cycles
    int          exp_busy;    // number of busy cycles
    logic [15:0] exp_wbits;   // mem_write per busy cycle, oldest in higher bits
    logic        chk_seq;     // compare the first four busy addresses
    logic [8:0]  a1;
    logic [15:0] v1;
    logic [8:0]  a2;
    logic [15:0] v2;
  } vec_t;

  vec_t       vecs[7];
  logic [8:0] pos_log[4];
  int         npos;

  // Pulses start, then observes each cycle until done or the cycle budget runs out.
  task automatic run_op(input vec_t v, output int lat, output int wr, output int bsy,
                        output logic [15:0] wbits);
    @(negedge sinal_clock);
    modo       = v.modo;
    origem     = v.origem;
    destino    = v.destino;
    quantidade = v.quantidade;
    padrao     = v.padrao;
    start      = 1'b1;
    @(negedge sinal_clock);
    start = 1'b0;
    lat   = 0;
    wr    = 0;
    bsy   = 0;
    wbits = 16'h0000;
    npos  = 0;
    for (int c = 1; c <= 2000; c++) begin
      if (mem_write) wr++;
      if (busy) begin
        bsy++;
        wbits = {wbits[14:0], mem_write};
        if (npos < 4) begin
          pos_log[npos] = mem_posicao;
          npos++;
        end
      end
      if (done) begin
        lat = c;
        break;
      end
      @(negedge sinal_clock);
    end
  endtask

  initial begin
    int          lat;
    int          wr;
    int          bsy;
    int          cnt;
    int          dones;
    int          done_at;
    logic [15:0] wbits;
    logic [8:0]  seq_exp[4];
    vec_t        v;

    seq_exp = '{9'd510, 9'd511, 9'd0, 9'd1};

    //        modo   orig    dest    qtd       padrao    erro  soma     lat  wr   busy wbits     seq   a1      v1        a2      v2
    vecs[0] = '{2'b00, 9'd0,   9'd10,  10'd4,   16'hBEEF, 1'b0, 16'h0000, 5,   4,   4,   16'h000F, 1'b0, 9'd10,  16'hBEEF, 9'd14,  16'h0000};
    vecs[1] = '{2'b01, 9'd100, 9'd300, 10'd3,   16'h0000, 1'b0, 16'h0000, 7,   3,   6,   16'h0015, 1'b0, 9'd300, 16'h0001, 9'd302, 16'h0003};
    vecs[2] = '{2'b10, 9'd510, 9'd0,   10'd4,   16'h0000, 1'b0, 16'h0008, 5,   0,   4,   16'h0000, 1'b1, 9'd0,   16'h0003, 9'd1,   16'h0004};
    vecs[3] = '{2'b00, 9'd0,   9'd20,  10'd513, 16'h1111, 1'b1, 16'h0000, 1,   0,   0,   16'h0000, 1'b0, 9'd20,  16'h0000, 9'd21,  16'h0000};
    vecs[4] = '{2'b00, 9'd0,   9'd40,  10'd0,   16'h7777, 1'b0, 16'h0000, 1,   0,   0,   16'h0000, 1'b0, 9'd40,  16'h0000, 9'd41,  16'h0000};
    vecs[5] = '{2'b11, 9'd0,   9'd50,  10'd5,   16'h2222, 1'b1, 16'h0000, 1,   0,   0,   16'h0000, 1'b0, 9'd50,  16'h0000, 9'd51,  16'h0000};
    vecs[6] = '{2'b00, 9'd0,   9'd7,   10'd512, 16'h5A5A, 1'b0, 16'h0000, 513, 512, 512, 16'hFFFF, 1'b0, 9'd6,   16'h5A5A, 9'd7,   16'h5A5A};

    sinal_reset = 1'b1;
    start       = 1'b0;
    modo        = 2'b00;
    origem      = '0;
    destino     = '0;
    quantidade  = '0;
    padrao      = '0;
    tb_we       = 1'b0;
    tb_clr      = 1'b0;
    tb_addr     = '0;
    tb_data     = '0;

    // Reset state.
    repeat (3) @(negedge sinal_clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_erro", 32'(erro), 32'd0);
    check("rst_soma", 32'(soma), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_posicao", 32'(mem_posicao), 32'd0);
    check("rst_mem_entrada", 32'(mem_entrada), 32'd0);
    sinal_reset = 1'b0;

    mem_clear();
    mem_load(9'd100, 16'h0001);
    mem_load(9'd101, 16'h0002);
    mem_load(9'd102, 16'h0003);
    mem_load(9'd510, 16'hFFFF);
    mem_load(9'd511, 16'h0002);
    mem_load(9'd0,   16'h0003);
    mem_load(9'd1,   16'h0004);

    // Table of operations.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], lat, wr, bsy, wbits);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_writes", i), 32'(wr), 32'(vecs[i].exp_wr));
      check($sformatf("v%0d_busy_cycles", i), 32'(bsy), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d_write_pattern", i), 32'(wbits), 32'(vecs[i].exp_wbits));
      if (vecs[i].chk_seq) begin
        for (int k = 0; k < 4; k++)
          check($sformatf("v%0d_addr%0d", i, k), 32'(pos_log[k]), 32'(seq_exp[k]));
      end
      @(negedge sinal_clock);
      check($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
      check($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_erro", i), 32'(erro), 32'(vecs[i].exp_erro));
      check($sformatf("v%0d_soma", i), 32'(soma), 32'(vecs[i].exp_soma));
      check($sformatf("v%0d_mem_a1", i), 32'(mem[vecs[i].a1]), 32'(vecs[i].v1));
      check($sformatf("v%0d_mem_a2", i), 32'(mem[vecs[i].a2]), 32'(vecs[i].v2));
    end

    // Full-memory fill reached every word.
    cnt = 0;
    for (int k = 0; k < 512; k++) if (mem[k] == 16'h5A5A) cnt++;
    check("fill512_all_words", 32'(cnt), 32'd512);

    // Reset mid-fill: reset is sampled at the edge that commits the 5th write.
    mem_clear();
    @(negedge sinal_clock);
    modo       = 2'b00;
    destino    = 9'd200;
    quantidade = 10'd20;
    padrao     = 16'h1234;
    start      = 1'b1;
    @(negedge sinal_clock);
    start = 1'b0;
    repeat (4) @(negedge sinal_clock);
    check("midrst_writing", 32'(mem_write), 32'd1);
    sinal_reset = 1'b1;
    @(negedge sinal_clock);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_erro", 32'(erro), 32'd0);
    check("midrst_soma", 32'(soma), 32'd0);
    check("midrst_mem_write", 32'(mem_write), 32'd0);
    check("midrst_mem_posicao", 32'(mem_posicao), 32'd0);
    check("midrst_mem_entrada", 32'(mem_entrada), 32'd0);
    sinal_reset = 1'b0;
    repeat (2) @(negedge sinal_clock);
    cnt = 0;
    for (int k = 0; k < 512; k++) if (mem[k] == 16'h1234) cnt++;
    check("midrst_words_written", 32'(cnt), 32'd5);
    check("midrst_word204", 32'(mem[204]), 32'h1234);
    check("midrst_word205", 32'(mem[205]), 32'h0000);
    v = '{2'b10, 9'd200, 9'd0, 10'd5, 16'h0000, 1'b0, 16'h5B04, 6, 0, 5, 16'h0000, 1'b0,
          9'd0, 16'h0000, 9'd0, 16'h0000};
    run_op(v, lat, wr, bsy, wbits);
    check("after_rst_latency", 32'(lat), 32'(v.exp_lat));
    check("after_rst_soma", 32'(soma), 32'(v.exp_soma));
    check("after_rst_writes", 32'(wr), 32'(v.exp_wr));

    // start while busy: a second request with different operands is held high
    // from cycle 2 through the FIM cycle and must not be accepted.
    mem_clear();
    mem_load(9'd400, 16'hAAAA);
    mem_load(9'd401, 16'hBBBB);
    @(negedge sinal_clock);
    modo       = 2'b01;
    origem     = 9'd400;
    destino    = 9'd450;
    quantidade = 10'd2;
    padrao     = 16'h0000;
    start      = 1'b1;
    @(negedge sinal_clock);
    start   = 1'b0;
    dones   = 0;
    done_at = 0;
    wr      = 0;
    for (int c = 1; c <= 12; c++) begin
      if (done) begin
        dones++;
        done_at = c;
      end
      if (mem_write) wr++;
      if (c == 2) begin
        start      = 1'b1;
        modo       = 2'b00;
        origem     = 9'd0;
        destino    = 9'd460;
        quantidade = 10'd3;
        padrao     = 16'h9999;
      end
      if (c == 6) start = 1'b0;
      @(negedge sinal_clock);
    end
    check("busy_start_dones", 32'(dones), 32'd1);
    check("busy_start_done_cycle", 32'(done_at), 32'd5);
    check("busy_start_writes", 32'(wr), 32'd2);
    check("busy_start_idle", 32'(busy), 32'd0);
    check("busy_start_word450", 32'(mem[450]), 32'hAAAA);
    check("busy_start_word451", 32'(mem[451]), 32'hBBBB);
    check("busy_start_word460", 32'(mem[460]), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
